// File: rtl/div_sequencer_pkg.sv
// rtl/div_sequencer_pkg.sv - shared opcodes, DIV sequencer state encodings and width default
package div_sequencer_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [5:0] R_Type = 6'h00;
    localparam logic [5:0] ADDI   = 6'h08;
    localparam logic [5:0] ORI    = 6'h0d;
    localparam logic [5:0] MOV    = 6'h41;
    localparam logic [5:0] DIV    = 6'h42;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring shift-subtract iteration, combinational
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rIn,
    input  logic [WIDTH-1:0] qIn,
    input  logic [WIDTH-1:0] dIn,
    output logic [WIDTH:0]   rOut,
    output logic [WIDTH-1:0] qOut
);

    // One extra bit keeps the whole shifted remainder in the subtraction so its MSB is the borrow.
    logic [WIDTH+1:0] trial;
    logic             negative;

    assign trial    = {rIn, qIn[WIDTH-1]} - {2'b00, dIn};
    assign negative = trial[WIDTH+1];

    always_comb begin
        rOut = trial[WIDTH:0];
        qOut = {qIn[WIDTH-2:0], 1'b1};
        if (negative) begin
            rOut = {rIn[WIDTH-1:0], qIn[WIDTH-1]};
            qOut = {qIn[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - multi-cycle unsigned DIV sequencer with fetch stall and write-back strobe
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       OP,
    input  logic             InstrValid,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Stall,
    output logic             Done,
    output logic             WriteEn,
    output logic             DivByZero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [WIDTH:0]   r;
    logic [CNT_W-1:0] count;
    logic [WIDTH:0]   stepR;
    logic [WIDTH-1:0] stepQ;
    logic             start;

    div_step #(.WIDTH(WIDTH)) uStep (
        .rIn  (r),
        .qIn  (q),
        .dIn  (d),
        .rOut (stepR),
        .qOut (stepQ)
    );

    assign start   = (state == IDLE) && InstrValid && (OP == DIV);
    assign Stall   = reset && (start || (state == RUN));
    assign Done    = (state == DONE);
    assign WriteEn = Done;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            q         <= '0;
            d         <= '0;
            r         <= '0;
            count     <= '0;
            Quotient  <= '0;
            Remainder <= '0;
            DivByZero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (Divisor == '0) begin
                            state     <= DONE;
                            Quotient  <= '1;
                            Remainder <= Dividend;
                            DivByZero <= 1'b1;
                        end else begin
                            state     <= RUN;
                            q         <= Dividend;
                            d         <= Divisor;
                            r         <= '0;
                            count     <= CNT_W'(WIDTH);
                            DivByZero <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    q     <= stepQ;
                    r     <= stepR;
                    count <= count - 1'b1;
                    // The final iteration's result goes straight into the output registers.
                    if (count == CNT_W'(1)) begin
                        state     <= DONE;
                        Quotient  <= stepQ;
                        Remainder <= stepR[WIDTH-1:0];
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - randomized scoreboard bench for div_sequencer
module tb_div_sequencer;
    import div_sequencer_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [5:0]   OP = 6'h00;
    logic         InstrValid = 1'b0;
    logic [W-1:0] Dividend = '0;
    logic [W-1:0] Divisor = '0;
    logic [W-1:0] Quotient;
    logic [W-1:0] Remainder;
    logic         Stall;
    logic         Done;
    logic         WriteEn;
    logic         DivByZero;

    div_sequencer #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .OP         (OP),
        .InstrValid (InstrValid),
        .Dividend   (Dividend),
        .Divisor    (Divisor),
        .Quotient   (Quotient),
        .Remainder  (Remainder),
        .Stall      (Stall),
        .Done       (Done),
        .WriteEn    (WriteEn),
        .DivByZero  (DivByZero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int unsigned  at;
    } exp_t;

    exp_t        sb[$];
    exp_t        mexp;
    int          checks = 0;
    int          errors = 0;
    int unsigned cycle = 0;
    logic [5:0]  nonDiv[4];

    initial begin
        nonDiv[0] = R_Type;
        nonDiv[1] = ADDI;
        nonDiv[2] = ORI;
        nonDiv[3] = MOV;
    end

    always @(posedge clk) cycle++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int unsigned t);
        exp_t e;
        if (b == 0) begin
            e.q = {W{1'b1}};
            e.r = a;
            e.dbz = 1'b1;
            e.at = t + 1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.dbz = 1'b0;
            e.at = t + W + 1;
        end
        return e;
    endfunction

    // Monitor: every Done must match the oldest outstanding DIV.
    always @(negedge clk) begin
        if (Done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cycle);
            end else begin
                mexp = sb.pop_front();
                check("done_cycle", 64'(cycle), 64'(mexp.at));
                check("quotient", 64'(Quotient), 64'(mexp.q));
                check("remainder", 64'(Remainder), 64'(mexp.r));
                check("div_by_zero", 64'(DivByZero), 64'(mexp.dbz));
                check("write_en", 64'(WriteEn), 64'd1);
            end
        end else if (WriteEn) begin
            check("write_en_without_done", 64'(WriteEn), 64'd0);
        end
    end

    task automatic setIdleOp();
        int k;
        k = int'($urandom_range(0, 4));
        if (k == 4) begin
            OP = DIV;
            InstrValid = 1'b0;
        end else begin
            OP = nonDiv[k];
            InstrValid = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        setIdleOp();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_stall", 64'(Stall), 64'd0);
            @(posedge clk);
            #1;
            setIdleOp();
        end
    endtask

    // Called just after a rising edge; returns just after the edge following DONE.
    task automatic runDiv(input logic [W-1:0] a, input logic [W-1:0] b, input bit holdOp);
        int stallCnt;
        bit seen;
        stallCnt = 0;
        seen = 1'b0;
        OP = DIV;
        InstrValid = 1'b1;
        Dividend = a;
        Divisor = b;
        sb.push_back(model(a, b, cycle));
        for (int n = 0; n < W + 8 && !seen; n++) begin
            @(negedge clk);
            if (Stall) stallCnt++;
            if (Done) seen = 1'b1;
            @(posedge clk);
            #1;
            if (!holdOp && !seen) begin
                Dividend = $urandom;
                Divisor = $urandom;
                setIdleOp();
            end
        end
        check("done_seen", 64'(seen), 64'd1);
        check("stall_cycles", 64'(stallCnt), (b == 0) ? 64'd1 : 64'(W + 1));
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit hold;
        int kind;

        reset = 1'b0;
        OP = DIV;
        InstrValid = 1'b1;
        Dividend = 32'd100;
        Divisor = 32'd7;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_stall_forced", 64'(Stall), 64'd0);
        check("reset_quotient", 64'(Quotient), 64'd0);
        check("reset_remainder", 64'(Remainder), 64'd0);
        check("reset_done", 64'(Done), 64'd0);
        check("reset_write_en", 64'(WriteEn), 64'd0);
        check("reset_div_by_zero", 64'(DivByZero), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(2);

        runDiv(32'd100, 32'd7, 1'b0);
        idle(2);
        runDiv(32'd5, 32'd0, 1'b0);
        idle(1);
        runDiv(32'hFFFF_FFFF, 32'd1, 1'b0);
        runDiv(32'd3, 32'd10, 1'b0);

        OP = ADDI; InstrValid = 1'b1;
        repeat (4) begin @(negedge clk); check("addi_stall", 64'(Stall), 64'd0); @(posedge clk); #1; end
        OP = MOV; InstrValid = 1'b1;
        repeat (4) begin @(negedge clk); check("mov_stall", 64'(Stall), 64'd0); @(posedge clk); #1; end
        OP = DIV; InstrValid = 1'b0;
        repeat (4) begin @(negedge clk); check("bubble_stall", 64'(Stall), 64'd0); @(posedge clk); #1; end

        // Abandon a divide with reset sampled low at T+10.
        OP = DIV; InstrValid = 1'b1; Dividend = 32'd100; Divisor = 32'd7;
        @(posedge clk);
        #1;
        setIdleOp();
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_mid_stall_forced", 64'(Stall), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("after_reset_stall", 64'(Stall), 64'd0);
        check("after_reset_quotient", 64'(Quotient), 64'd0);
        check("after_reset_remainder", 64'(Remainder), 64'd0);
        check("after_reset_done", 64'(Done), 64'd0);
        @(posedge clk);
        #1;
        idle(30);
        runDiv(32'd50, 32'd5, 1'b0);
        idle(1);

        runDiv(32'd100, 32'd7, 1'b1);
        runDiv(32'd81, 32'd9, 1'b0);
        idle(2);

        for (int i = 0; i < 25; i++) begin
            a = $urandom;
            kind = int'($urandom_range(0, 3));
            case (kind)
                0:       b = '0;
                1:       b = W'($urandom_range(1, 15));
                2:       b = a + W'($urandom_range(0, 1));
                default: b = $urandom;
            endcase
            hold = 1'($urandom_range(0, 1));
            runDiv(a, b, hold);
            idle(int'($urandom_range(0, 2)));
        end

        idle(3);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle sequencer for the DIV instruction (opcode 6'h42) in the MIPS core. Decodes DIV from the instruction opcode, stalls instruction fetch, and runs an unsigned restoring shift-subtract divide, one quotient bit per cycle. Presents quotient and remainder to the write-back path with a one-cycle write enable. Sits beside Control; its Stall output gates the PC and IF register.

## Interface
- WIDTH, 32: operand and result width in bits.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- OP  in  6  opcode of the instruction currently in decode.
- InstrValid  in  1  OP is a real instruction, not a bubble.
- Dividend  in  WIDTH  rs value; sampled on the start cycle.
- Divisor  in  WIDTH  rt value; sampled on the start cycle.
- Quotient  out  WIDTH  registered result; held until the next DIV completes.
- Remainder  out  WIDTH  registered result; held until the next DIV completes.
- Stall  out  1  holds the PC and the IF register while high.
- Done  out  1  one-cycle pulse when the result is valid.
- WriteEn  out  1  register-file write strobe; equals Done.
- DivByZero  out  1  valid with Done; set when Divisor was 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE to RUN:
  - Start condition: InstrValid and OP==DIV, Divisor != 0.
  - Latch Dividend into Q, Divisor into D, clear the WIDTH+1-bit partial remainder R, load count=WIDTH.
  - Stall=1 combinationally during this start cycle.
- IDLE to DONE: start condition with Divisor==0.
  - Q=all ones, R=Dividend, DivByZero flag set.
- RUN, each cycle:
  - {R,Q} shifts left by 1.
  - trial = R - {1'b0,D}.
  - If trial is non-negative (MSB 0): R=trial and Q[0]=1. Otherwise R is unchanged after the shift and Q[0]=0.
  - count decrements. When count reaches 1, the next state is DONE.
  - Stall=1.
- DONE:
  - Quotient<=Q and Remainder<=R[WIDTH-1:0] on entry.
  - Done=WriteEn=1 and Stall=0, so the PC advances at the end of this cycle.
  - Always returns to IDLE. OP is still DIV here; it must not restart.
- Non-DIV opcode or InstrValid=0 in IDLE: Stall=0, no state change.
- Arithmetic is unsigned only. R is WIDTH+1 bits so the borrow is visible.

## Timing
- Start cycle T: IDLE with DIV decoded.
- RUN occupies T+1 to T+WIDTH. DONE is at T+WIDTH+1, for 33 cycles total at WIDTH=32.
- Stall is high from T through T+WIDTH and low in DONE.
- Divide by zero: Stall at T only. DONE, DivByZero, Done and WriteEn at T+1.
- DivByZero clears on the next start.
- Reset values (reset=0 at an edge): state=IDLE, Quotient=0, Remainder=0, Done=0, WriteEn=0, DivByZero=0, count=0.
- Stall is forced to 0 while reset is low.
- Reset mid-RUN: the operation is abandoned. There is no Done pulse and the outputs clear.
- Back-to-back DIV: the next DIV is decoded in the IDLE cycle after DONE, so there is no overlap.
- Operand changes during RUN are ignored; operands are latched.

## Structure
- The shared package/header holds:
  - the opcode constants R_Type=0, ADDI=6'h08, ORI=6'h0d, MOV=6'h41, DIV=6'h42, used by both Control and div_sequencer;
  - the state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the WIDTH default.
- Sub-module div_step: a combinational single iteration. Inputs R, Q, D; outputs next R and next Q. The FSM, counter and registers stay in div_sequencer.

## Test plan
- Basic divide: OP=6'h42, Dividend=100, Divisor=7.
  - Stall high for 33 cycles.
  - Done at T+33 with Quotient=14, Remainder=2, DivByZero=0.
- Divide by zero: Dividend=5, Divisor=0.
  - Stall for 1 cycle.
  - Done at T+1 with Quotient=32'hFFFFFFFF, Remainder=5, DivByZero=1.
- Extremes, each must give Done at T+33:
  - 32'hFFFFFFFF / 1: Quotient=32'hFFFFFFFF, Remainder=0.
  - 3 / 10: Quotient=0, Remainder=3.
- Non-DIV and bubble opcodes: OP=6'h08 (ADDI) and OP=6'h41 (MOV), each with InstrValid=1; then OP=6'h42 with InstrValid=0.
  - Stall stays 0, Done never pulses, state stays IDLE.
- Reset mid-operation: reset=0 at T+10 of a 100/7 divide.
  - Next cycle: IDLE, Stall=0, Quotient=0, no Done.
  - A following 50/5 divide gives Quotient=10, Remainder=0.
- Back-to-back: 100/7 with OP held at DIV through DONE, then 81/9.
  - Exactly one Done per DIV.
  - Second start is in the cycle after DONE; second result is Quotient=9, Remainder=0.
